// File: rtl/l2_write_buffer.sv
// Posted-write line buffer between L2 and main memory, with read forwarding from pending writes.
// Optional feature macro L2WB_COALESCE_EN: writes to an already-buffered line update it in place.
module l2_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       l2_valid_i,
  input  logic                       l2_rw_i,
  input  logic [ADDR_W-1:0]          l2_addr_i,
  input  logic [LINE_W-1:0]          l2_data_i,
  output logic                       l2_ready_o,
  output logic [LINE_W-1:0]          l2_data_o,
  output logic                       mem_valid_o,
  output logic                       mem_rw_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic [LINE_W-1:0]          mem_data_o,
  input  logic                       mem_ready_i,
  input  logic [LINE_W-1:0]          mem_data_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [LINE_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [CW-1:0]     r_count, w_count_nxt;
  logic              r_full, r_rd_pend, r_l2_ready;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [LINE_W-1:0] r_l2_data;

  logic              w_busy, w_sample, w_pop, w_push, w_coal_wr;
  logic              w_rd_hit, w_rd_miss, w_ack, w_hit;
  logic [PW-1:0]     w_hit_idx, w_idx;

  // Youngest valid entry matching the request address (scan oldest to youngest)
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (r_vld[w_idx] && (r_addr[w_idx] == l2_addr_i)) begin
        w_hit     = 1'b1;
        w_hit_idx = w_idx;
      end else begin
        w_hit     = w_hit;
      end
    end
  end

`ifdef L2WB_COALESCE_EN
  logic          w_coal_hit;
  logic [PW-1:0] w_coal_idx, w_cidx;

  // Coalescing target: youngest match other than the head line being drained
  always_comb begin
    w_coal_hit = 1'b0;
    w_coal_idx = '0;
    w_cidx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cidx = r_head + PW'(i);
      if (r_vld[w_cidx] && (r_addr[w_cidx] == l2_addr_i) &&
          !((r_state == S_DRAIN) && (w_cidx == r_head))) begin
        w_coal_hit = 1'b1;
        w_coal_idx = w_cidx;
      end else begin
        w_coal_hit = w_coal_hit;
      end
    end
  end

  assign w_coal_wr = w_sample && l2_rw_i && w_coal_hit;
`else
  assign w_coal_wr = 1'b0;
`endif

  // A latched miss blocks new requests until its response pulse
  assign w_busy      = r_rd_pend || (r_state == S_READ);
  assign w_sample    = l2_valid_i && !r_l2_ready && !w_busy;
  assign w_pop       = (r_state == S_DRAIN) && mem_ready_i;
  assign w_push      = w_sample && l2_rw_i && !w_coal_wr && ((r_count != CW'(DEPTH)) || w_pop);
  assign w_rd_hit    = w_sample && !l2_rw_i && w_hit;
  assign w_rd_miss   = w_sample && !l2_rw_i && !w_hit;
  assign w_ack       = w_push || w_coal_wr || w_rd_hit || ((r_state == S_READ) && mem_ready_i);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Memory-port next state: reads win over drains, drains are never cut short
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_rd_pend || w_rd_miss)  w_state_nxt = S_READ;
        else if (r_count != '0)      w_state_nxt = S_DRAIN;
        else                         w_state_nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (w_pop) w_state_nxt = (r_rd_pend || w_rd_miss) ? S_READ : S_IDLE;
        else       w_state_nxt = S_DRAIN;
      end
      S_READ:  w_state_nxt = mem_ready_i ? S_RESP : S_READ;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FIFO storage and occupancy; pop precedes push so a full push/pop reuses the head slot
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_push) begin
        r_vld[r_tail]  <= 1'b1;
        r_addr[r_tail] <= l2_addr_i;
        r_data[r_tail] <= l2_data_i;
        r_tail         <= r_tail + PW'(1);
      end
`ifdef L2WB_COALESCE_EN
      if (w_coal_wr) r_data[w_coal_idx] <= l2_data_i;
`endif
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  // Port state, pending miss and L2 response registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_rd_pend  <= 1'b0;
      r_rd_addr  <= '0;
      r_l2_ready <= 1'b0;
      r_l2_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_l2_ready <= w_ack;
      if (w_rd_miss) r_rd_addr <= l2_addr_i;
      if (w_state_nxt == S_READ) r_rd_pend <= 1'b0;
      else if (w_rd_miss)        r_rd_pend <= 1'b1;
      if (w_rd_hit)                                r_l2_data <= r_data[w_hit_idx];
      else if ((r_state == S_READ) && mem_ready_i) r_l2_data <= mem_data_i;
    end
  end

  assign mem_valid_o = (r_state == S_DRAIN) || (r_state == S_READ);
  assign mem_rw_o    = (r_state == S_DRAIN);
  assign mem_addr_o  = (r_state == S_DRAIN) ? r_addr[r_head] :
                       (r_state == S_READ)  ? r_rd_addr : '0;
  assign mem_data_o  = (r_state == S_DRAIN) ? r_data[r_head] : '0;
  assign l2_ready_o  = r_l2_ready;
  assign l2_data_o   = r_l2_data;
  assign full_o      = r_full;
  assign count_o     = r_count;
endmodule
